// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: state encoding and step count.
package mul16_seq_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam int unsigned MUL_STEPS = 16;
  localparam logic [3:0]  LAST_STEP = 4'(MUL_STEPS - 1);

endpackage

// File: rtl/mul16_seq_add16.sv
// 16-bit adder shared by the multiplier's accumulate step; wraps mod 2^16, no carry-out.
module add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul16_seq.sv
// Shift-and-add 16x16 multiplier producing the low 16 product bits after 16 fixed steps.
module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        busy,
  output logic        done
);

  mul_state_e  state_q;
  logic [15:0] mcand_q;
  logic [15:0] mplier_q;
  logic [15:0] acc_q;
  logic [3:0]  cnt_q;
  logic [15:0] out_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] sum_s;
  logic [15:0] acc_d;

  add16 acc_add (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (sum_s)
  );

  assign acc_d = mplier_q[0] ? sum_s : acc_q;

  // Controller, datapath registers and registered status outputs in one FSM block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= 16'd0;
      mplier_q <= 16'd0;
      acc_q    <= 16'd0;
      cnt_q    <= 4'd0;
      out_q    <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= 16'd0;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b1;
            state_q  <= MUL_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= MUL_IDLE;
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[15:1]};
          cnt_q    <= cnt_q + 4'd1;
          // The last step's add must land in out directly, not via acc_q.
          if (cnt_q == LAST_STEP) begin
            out_q   <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MUL_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= MUL_RUN;
          end
        end
        MUL_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= MUL_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= MUL_IDLE;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
